core_div: RTL and testbench

- Multi-cycle signed divider that sits beside the combinational core ALU and provides the inverse of its MUL and FMUL operations.
- Integer mode (DIV) returns quotient and remainder.
- Fixed-point mode (FDIV) pre-scales the dividend left by `precision` bits, so the quotient stays in the same Q format that FMUL consumes.
- The core issues one division through a start/ready handshake and collects the result through a valid/ready handshake.

---
 rtl/core_div.sv | 172 +++++++++++++++++
 tb/tb_core_div.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/core_div.sv
// Multi-cycle signed restoring divider (DIV and fixed-point FDIV) with start/ready and valid/ready handshakes.
// Optional macro CORE_DIV_EARLY_TERM_EN skips leading zero numerator bits at acceptance.
module core_div #(
  parameter int WIDTH = 32,
  parameter int EXT   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic             fdiv,
  input  logic [4:0]       precision,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam int NW = WIDTH + EXT;
  localparam int CW = $clog2(NW + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t           state_r, state_s;
  logic [NW-1:0]    num_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] part_r;
  logic [WIDTH-1:0] dvs_r;
  logic             sign_q_r, sign_r_r;
  logic [CW-1:0]    cnt_r;

  logic [WIDTH-1:0] abs_a_s, abs_b_s;
  logic [NW-1:0]    num_start_s;
  logic [CW-1:0]    cnt_init_s, cnt_start_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] sub_s;
  logic             ge_s;
  logic [WIDTH-1:0] q_fin_s, r_fin_s;
  logic             zero_div_s;

`ifdef CORE_DIV_EARLY_TERM_EN
  logic [CW-1:0]    lz_s;

  function automatic logic [CW-1:0] clz(input logic [NW-1:0] v);
    clz = CW'(NW);
    for (int i = 0; i < NW; i++) begin
      if (v[i]) clz = CW'(NW - 1 - i);
    end
  endfunction
`endif

  // Operand conditioning at acceptance; the numerator is left-aligned so the
  // first N steps consume exactly |dividend| << precision (or |dividend| in DIV).
  always_comb begin
    abs_a_s     = dividend[WIDTH-1] ? (~dividend + {{(WIDTH-1){1'b0}}, 1'b1}) : dividend;
    abs_b_s     = divisor[WIDTH-1]  ? (~divisor  + {{(WIDTH-1){1'b0}}, 1'b1}) : divisor;
    zero_div_s  = (divisor == {WIDTH{1'b0}});
    cnt_init_s  = fdiv ? (CW'(WIDTH) + CW'(precision)) : CW'(WIDTH);
`ifdef CORE_DIV_EARLY_TERM_EN
    lz_s        = clz({abs_a_s, {EXT{1'b0}}});
    num_start_s = {abs_a_s, {EXT{1'b0}}} << lz_s;
    cnt_start_s = (cnt_init_s > lz_s) ? (cnt_init_s - lz_s) : CW'(1);
`else
    num_start_s = {abs_a_s, {EXT{1'b0}}};
    cnt_start_s = cnt_init_s;
`endif
  end

  // One restoring step plus sign fix-up of the final result.
  always_comb begin
    trial_s = {part_r, num_r[NW-1]};
    ge_s    = (trial_s >= {1'b0, dvs_r});
    sub_s   = trial_s[WIDTH-1:0] - dvs_r;
    q_fin_s = sign_q_r ? (~quo_r + {{(WIDTH-1){1'b0}}, 1'b1}) : quo_r;
    r_fin_s = sign_r_r ? (~part_r + {{(WIDTH-1){1'b0}}, 1'b1}) : part_r;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = zero_div_s ? DONE : CALC;
        else       state_s = IDLE;
      end
      CALC: begin
        if (cnt_r == {CW{1'b0}}) state_s = DONE;
        else                     state_s = CALC;
      end
      DONE: begin
        if (result_ready) state_s = IDLE;
        else              state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    ready        = 1'b0;
    result_valid = 1'b0;
    case (state_r)
      IDLE:    ready = 1'b1;
      CALC:    ready = 1'b0;
      DONE:    result_valid = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Datapath: operand capture, iteration and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_r       <= {NW{1'b0}};
      quo_r       <= {WIDTH{1'b0}};
      part_r      <= {WIDTH{1'b0}};
      dvs_r       <= {WIDTH{1'b0}};
      sign_q_r    <= 1'b0;
      sign_r_r    <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      quotient    <= {WIDTH{1'b0}};
      remainder   <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            num_r    <= num_start_s;
            quo_r    <= {WIDTH{1'b0}};
            part_r   <= {WIDTH{1'b0}};
            dvs_r    <= abs_b_s;
            sign_q_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r_r <= dividend[WIDTH-1];
            cnt_r    <= cnt_start_s;
            if (zero_div_s) begin
              quotient    <= {WIDTH{1'b1}};
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          if (cnt_r != {CW{1'b0}}) begin
            num_r  <= {num_r[NW-2:0], 1'b0};
            part_r <= ge_s ? sub_s : trial_s[WIDTH-1:0];
            quo_r  <= {quo_r[WIDTH-2:0], ge_s};
            cnt_r  <= cnt_r - CW'(1);
          end else begin
            quotient    <= q_fin_s;
            remainder   <= r_fin_s;
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_div.sv
// Directed self-checking bench for core_div (WIDTH = 32, early termination disabled).
module tb_core_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready;
  logic        fdiv = 1'b0;
  logic [4:0]  precision = 5'd0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        result_valid;
  logic        result_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  core_div dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .fdiv(fdiv),
    .precision(precision), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  // Issue one operation, scramble inputs after acceptance, and count edges
  // after the accept edge until result_valid (0 = valid at the accept edge).
  task automatic run_op(input logic f, input logic [4:0] p, input logic [31:0] a,
                        input logic [31:0] b, output int lat, output logic rdy_low);
    @(negedge clk);
    start = 1'b1; fdiv = f; precision = p; dividend = a; divisor = b; result_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; fdiv = ~f; precision = 5'd7; dividend = 32'h5A5A_5A5A; divisor = 32'h0000_0003;
    lat = 0; rdy_low = 1'b1;
    while (result_valid !== 1'b1 && lat < 200) begin
      if (ready !== 1'b0) rdy_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (ready !== 1'b0) rdy_low = 1'b0;
    @(negedge clk);
  endtask

  task automatic retire();
    @(negedge clk); result_ready = 1'b1;
    @(posedge clk); #1; result_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready); end
    tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", result_valid); end
    tests++; if (quotient !== 32'd0 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      fails++; $display("FAIL reset_outputs got q=%h r=%h z=%b want 0/0/0", quotient, remainder, div_by_zero); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_div();
    logic [31:0] a_v [5] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'h8000_0000, 32'hFFFF_FF9C};
    logic [31:0] b_v [5] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    logic [31:0] q_v [5] = '{32'd14, 32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'h8000_0000, 32'd14};
    logic [31:0] r_v [5] = '{32'd2, 32'hFFFF_FFFE, 32'd2, 32'd0, 32'hFFFF_FFFE};
    int lat; logic rl;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, 5'd0, a_v[i], b_v[i], lat, rl);
      tests++; if (quotient !== q_v[i]) begin fails++; $display("FAIL div%0d_q got %h want %h", i, quotient, q_v[i]); end
      tests++; if (remainder !== r_v[i]) begin fails++; $display("FAIL div%0d_r got %h want %h", i, remainder, r_v[i]); end
      tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL div%0d_dz got %b want 0", i, div_by_zero); end
      tests++; if (lat !== 33) begin fails++; $display("FAIL div%0d_latency got %0d want 33", i, lat); end
      tests++; if (rl !== 1'b1) begin fails++; $display("FAIL div%0d_ready_low got %b want 1", i, rl); end
      retire();
      tests++; if (ready !== 1'b1 || result_valid !== 1'b0) begin
        fails++; $display("FAIL div%0d_retire got ready=%b valid=%b want 1/0", i, ready, result_valid); end
    end
  endtask

  task automatic test_fdiv();
    logic [31:0] a_v [2] = '{32'h0003_0000, 32'hFFFD_0000};
    logic [31:0] q_v [2] = '{32'h0001_8000, 32'hFFFE_8000};
    int lat; logic rl;
    for (int i = 0; i < 2; i++) begin
      run_op(1'b1, 5'd16, a_v[i], 32'h0002_0000, lat, rl);
      tests++; if (quotient !== q_v[i]) begin fails++; $display("FAIL fdiv%0d_q got %h want %h", i, quotient, q_v[i]); end
      tests++; if (remainder !== 32'd0) begin fails++; $display("FAIL fdiv%0d_r got %h want 0", i, remainder); end
      tests++; if (lat !== 49) begin fails++; $display("FAIL fdiv%0d_latency got %0d want 49", i, lat); end
      retire();
    end
  endtask

  task automatic test_div_by_zero();
    int lat; logic rl;
    run_op(1'b0, 5'd0, 32'd5, 32'd0, lat, rl);
    tests++; if (quotient !== 32'hFFFF_FFFF) begin fails++; $display("FAIL dz_q got %h want ffffffff", quotient); end
    tests++; if (remainder !== 32'd5) begin fails++; $display("FAIL dz_r got %h want 5", remainder); end
    tests++; if (div_by_zero !== 1'b1) begin fails++; $display("FAIL dz_flag got %b want 1", div_by_zero); end
    tests++; if (lat !== 0) begin fails++; $display("FAIL dz_latency got %0d extra edges want 0 (valid at accept edge)", lat); end
    retire();
    // A normal divide after a divide-by-zero must clear the flag.
    run_op(1'b0, 5'd0, 32'd9, 32'd3, lat, rl);
    tests++; if (div_by_zero !== 1'b0 || quotient !== 32'd3) begin
      fails++; $display("FAIL dz_clear got z=%b q=%h want 0/3", div_by_zero, quotient); end
    retire();
  endtask

  task automatic test_backpressure();
    int lat; logic rl;
    run_op(1'b0, 5'd0, 32'd1000, 32'hFFFF_FFFD, lat, rl);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); start = 1'b1; dividend = 32'd7; divisor = 32'd1;
      @(negedge clk);
      tests++; if (quotient !== 32'hFFFF_FEB3 || remainder !== 32'd1) begin
        fails++; $display("FAIL bp%0d_hold got q=%h r=%h want fffffeb3/1", c, quotient, remainder); end
      tests++; if (result_valid !== 1'b1 || ready !== 1'b0) begin
        fails++; $display("FAIL bp%0d_handshake got valid=%b ready=%b want 1/0", c, result_valid, ready); end
    end
    start = 1'b0;
    retire();
    tests++; if (ready !== 1'b1 || result_valid !== 1'b0) begin
      fails++; $display("FAIL bp_release got ready=%b valid=%b want 1/0", ready, result_valid); end
  endtask

  task automatic test_reset_mid_calc();
    int lat; logic rl;
    @(negedge clk); start = 1'b1; fdiv = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #2; rst = 1'b1; #1;
    tests++; if (ready !== 1'b1 || result_valid !== 1'b0) begin
      fails++; $display("FAIL rstmid_handshake got ready=%b valid=%b want 1/0", ready, result_valid); end
    tests++; if (quotient !== 32'd0) begin fails++; $display("FAIL rstmid_q got %h want 0", quotient); end
    @(negedge clk); rst = 1'b0;
    run_op(1'b0, 5'd0, 32'd100, 32'd7, lat, rl);
    tests++; if (quotient !== 32'd14 || remainder !== 32'd2 || lat !== 33) begin
      fails++; $display("FAIL rstmid_fresh got q=%h r=%h lat=%0d want e/2/33", quotient, remainder, lat); end
    retire();
  endtask

  initial begin
    test_reset();
    test_div();
    test_fdiv();
    test_div_by_zero();
    test_backpressure();
    test_reset_mid_calc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
